// File: rtl/microwave_display.sv
// Display stage of the microwave timer: converts remaining seconds to MM:SS BCD,
// scans a 4-digit active-low 7-segment display and runs the finish alarm.
module microwave_display #(
    parameter int SCAN_DIV   = 4,
    parameter int BLINK_DIV  = 8,
    parameter int BEEP_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  countDown,
    input  logic        finish,
    output logic [15:0] bcd,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        colon,
    output logic        beep,
    output logic        alarm
);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int BEEP_W  = $clog2(BEEP_COUNT + 1);

    typedef enum logic [2:0] {IDLE, MIN, SEC, MINT, COMMIT} state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [9:0]  work_q, work_d, last_cd_q, last_cd_d;
    logic [4:0]  mins_q, mins_d;
    logic [3:0]  min_t_q, min_t_d, min_u_q, min_u_d;
    logic [3:0]  sec_t_q, sec_t_d, sec_u_q, sec_u_d;
    logic [15:0] bcd_q, bcd_d;
    logic        busy_q;

    // Conversion: repeated subtraction, one step per cycle
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        last_cd_d = last_cd_q;
        mins_d    = mins_q;
        min_t_d   = min_t_q;
        min_u_d   = min_u_q;
        sec_t_d   = sec_t_q;
        sec_u_d   = sec_u_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (countDown != last_cd_q) begin
                    work_d    = countDown;
                    last_cd_d = countDown;
                    mins_d    = 5'd0;
                    min_t_d   = 4'd0;
                    min_u_d   = 4'd0;
                    sec_t_d   = 4'd0;
                    sec_u_d   = 4'd0;
                    state_d   = MIN;
                end
            end
            MIN: begin
                if (work_q >= 10'd60) begin
                    work_d = work_q - 10'd60;
                    mins_d = mins_q + 5'd1;
                end else begin
                    state_d = SEC;
                end
            end
            SEC: begin
                if (work_q >= 10'd10) begin
                    work_d  = work_q - 10'd10;
                    sec_t_d = sec_t_q + 4'd1;
                end else begin
                    sec_u_d = work_q[3:0];
                    state_d = MINT;
                end
            end
            MINT: begin
                if (mins_q >= 5'd10) begin
                    mins_d  = mins_q - 5'd10;
                    min_t_d = min_t_q + 4'd1;
                end else begin
                    min_u_d = mins_q[3:0];
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                bcd_d   = {min_t_q, min_u_q, sec_t_q, sec_u_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_cd_q <= 10'd0;
            bcd_q     <= 16'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_cd_q <= last_cd_d;
            bcd_q     <= bcd_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    // Scratch datapath is always initialised in IDLE before use, so it needs no reset
    always_ff @(posedge clk) begin
        work_q  <= work_d;
        mins_q  <= mins_d;
        min_t_q <= min_t_d;
        min_u_q <= min_u_d;
        sec_t_q <= sec_t_d;
        sec_u_q <= sec_u_d;
    end

    logic [SCAN_W-1:0] scan_cnt_q;
    logic [1:0]        idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
        end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            idx_q      <= idx_q + 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
        end
    end

    logic               finish_q, finish_rise;
    logic               alarm_q, alarm_d, phase_on_q, phase_on_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [BEEP_W-1:0]  ons_q, ons_d;

    assign finish_rise = finish & ~finish_q;

    always_comb begin
        alarm_d    = alarm_q;
        phase_on_d = phase_on_q;
        blink_d    = blink_q;
        ons_d      = ons_q;
        if (finish_rise) begin
            alarm_d    = 1'b1;
            phase_on_d = 1'b1;
            blink_d    = '0;
            ons_d      = '0;
        end else if (alarm_q && !finish) begin
            alarm_d    = 1'b0;
            phase_on_d = 1'b0;
            blink_d    = '0;
            ons_d      = '0;
        end else if (alarm_q) begin
            if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_d = '0;
                if (phase_on_q) begin
                    phase_on_d = 1'b0;
                    ons_d      = ons_q + BEEP_W'(1);
                end else if (ons_q == BEEP_W'(BEEP_COUNT)) begin
                    alarm_d = 1'b0;
                end else begin
                    phase_on_d = 1'b1;
                end
            end else begin
                blink_d = blink_q + BLINK_W'(1);
            end
        end
    end

    logic [3:0] nibble;
    logic [6:0] seg_d;
    logic [3:0] an_d;

    // Display outputs use the next alarm phase so an blanks on the same edge beep drops
    always_comb begin
        case (idx_q)
            2'd0:    nibble = bcd_q[3:0];
            2'd1:    nibble = bcd_q[7:4];
            2'd2:    nibble = bcd_q[11:8];
            default: nibble = bcd_q[15:12];
        endcase
        seg_d = seg_decode(nibble);
        if (idx_q == 2'd3 && bcd_q[15:12] == 4'd0)
            seg_d = 7'h7F;
        an_d = ~(4'b0001 << idx_q);
        if (alarm_d && !phase_on_d)
            an_d = 4'hF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            finish_q   <= 1'b0;
            alarm_q    <= 1'b0;
            phase_on_q <= 1'b0;
            blink_q    <= '0;
            ons_q      <= '0;
            beep       <= 1'b0;
            an         <= 4'b1110;
            seg        <= 7'b1000000;
            colon      <= 1'b1;
        end else begin
            finish_q   <= finish;
            alarm_q    <= alarm_d;
            phase_on_q <= phase_on_d;
            blink_q    <= blink_d;
            ons_q      <= ons_d;
            beep       <= alarm_d & phase_on_d;
            an         <= an_d;
            seg        <= seg_d;
            colon      <= (idx_q != 2'd2);
        end
    end

    assign bcd   = bcd_q;
    assign busy  = busy_q;
    assign alarm = alarm_q;
endmodule

// File: tb/tb_microwave_display.sv
// Directed bench for microwave_display: conversion, scanning, alarm and reset abort.
module tb_microwave_display;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  countDown;
    logic        finish;
    logic [15:0] bcd;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        colon;
    logic        beep;
    logic        alarm;

    int n_chk  = 0;
    int n_fail = 0;

    microwave_display #(.SCAN_DIV(4), .BLINK_DIV(8), .BEEP_COUNT(3)) dut (
        .clk(clk), .rst(rst), .countDown(countDown), .finish(finish),
        .bcd(bcd), .busy(busy), .an(an), .seg(seg), .colon(colon),
        .beep(beep), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bcd"}, bcd, 16'h0000);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_an"}, an, 4'b1110);
        chk({tag, "_seg"}, seg, 7'b1000000);
        chk({tag, "_colon"}, colon, 1'b1);
        chk({tag, "_beep"}, beep, 1'b0);
        chk({tag, "_alarm"}, alarm, 1'b0);
    endtask

    // Apply a value, confirm busy rises, then wait (bounded) for the commit cycle
    task automatic convert(input string tag, input logic [9:0] v);
        int c;
        countDown = v;
        tick(1);
        chk({tag, "_busy_rise"}, busy, 1'b1);
        c = 0;
        while (busy === 1'b1 && c < 29) begin
            tick(1);
            c++;
        end
        chk({tag, "_done"}, busy, 1'b0);
    endtask

    task automatic scan_digits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
        logic [3:0] seen;
        logic [6:0] exp;
        seen = 4'h0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            exp = 7'h00;
            case (an)
                4'b1110: begin exp = e0; seen[0] = 1'b1; end
                4'b1101: begin exp = e1; seen[1] = 1'b1; end
                4'b1011: begin exp = e2; seen[2] = 1'b1; end
                4'b0111: begin exp = e3; seen[3] = 1'b1; end
                default: chk({tag, "_an_onehot"}, an, 4'b1110);
            endcase
            chk({tag, "_seg"}, seg, exp);
            chk({tag, "_colon"}, colon, (an == 4'b1011) ? 1'b0 : 1'b1);
        end
        chk({tag, "_digits_seen"}, seen, 4'hF);
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] exp_an;
        int c;

        rst = 1'b1;
        countDown = 10'd0;
        finish = 1'b0;
        tick(2);
        chk_reset("reset");
        rst = 1'b0;
        tick(3);
        chk("idle_busy", busy, 1'b0);

        // 125 s -> 02:05
        convert("c125", 10'd125);
        chk("c125_bcd", bcd, 16'h0205);
        tick(2);
        scan_digits("c125", 7'h7F, 7'b0100100, 7'b1000000, 7'b0010010);

        // 1023 s -> 17:03
        convert("c1023", 10'd1023);
        chk("c1023_bcd", bcd, 16'h1703);
        tick(2);
        scan_digits("c1023", 7'b1111001, 7'b1111000, 7'b1000000, 7'b0110000);

        // 125 then 59 while busy: first result commits, then a second conversion
        countDown = 10'd125;
        tick(1);
        chk("chg_busy_rise", busy, 1'b1);
        countDown = 10'd59;
        c = 0;
        while (busy === 1'b1 && c < 29) begin
            tick(1);
            c++;
        end
        chk("chg_first_done", busy, 1'b0);
        chk("chg_first_bcd", bcd, 16'h0205);
        tick(1);
        chk("chg_second_busy", busy, 1'b1);
        c = 0;
        while (busy === 1'b1 && c < 29) begin
            tick(1);
            c++;
        end
        chk("chg_second_done", busy, 1'b0);
        chk("chg_second_bcd", bcd, 16'h0059);
        tick(2);
        scan_digits("c59", 7'h7F, 7'b1000000, 7'b0010010, 7'b0010000);

        // Scan period: each digit enable held exactly four cycles
        prev = an;
        tick(1);
        c = 0;
        while (!(an == 4'hE && prev != 4'hE) && c < 20) begin
            prev = an;
            tick(1);
            c++;
        end
        chk("scan_sync", an, 4'hE);
        for (int j = 0; j < 32; j++) begin
            exp_an = ~(4'b0001 << ((j / 4) % 4));
            chk("scan_an", an, exp_an);
            tick(1);
        end

        // Full alarm: three 8-cycle beeps, each followed by 8 dark cycles
        finish = 1'b1;
        for (int j = 0; j < 48; j++) begin
            tick(1);
            chk("alarm_on", alarm, 1'b1);
            chk("alarm_beep", beep, ((j / 8) % 2 == 0) ? 1'b1 : 1'b0);
            if ((j / 8) % 2 == 1)
                chk("alarm_off_an", an, 4'hF);
            else
                chk("alarm_on_an_lit", (an != 4'hF), 1'b1);
        end
        for (int j = 0; j < 20; j++) begin
            tick(1);
            chk("alarm_no_retrig", alarm, 1'b0);
            chk("alarm_no_retrig_beep", beep, 1'b0);
        end

        // finish drops 12 cycles into a new alarm
        finish = 1'b0;
        tick(2);
        finish = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick(1);
            chk("abort_pre_alarm", alarm, 1'b1);
        end
        finish = 1'b0;
        tick(1);
        chk("abort_alarm", alarm, 1'b0);
        chk("abort_beep", beep, 1'b0);
        chk("abort_an_lit", (an != 4'hF), 1'b1);

        // Reset during a conversion of 600: no late commit
        countDown = 10'd600;
        tick(1);
        chk("rst_conv_busy", busy, 1'b1);
        tick(3);
        rst = 1'b1;
        countDown = 10'd0;
        tick(1);
        chk_reset("rst_conv");
        rst = 1'b0;
        for (int j = 0; j < 30; j++) tick(1);
        chk("rst_conv_no_commit", bcd, 16'h0000);
        chk("rst_conv_idle", busy, 1'b0);

        // Reset during an alarm
        finish = 1'b1;
        tick(5);
        chk("rst_alarm_pre", alarm, 1'b1);
        rst = 1'b1;
        finish = 1'b0;
        tick(1);
        chk_reset("rst_alarm");
        rst = 1'b0;
        tick(3);
        chk("rst_alarm_stays_off", alarm, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
